thread_registers: RTL and testbench

Per-thread register file that sits directly upstream of the ALU in each core lane: it supplies the `rs`/`rt` operands the ALU consumes, and on writeback it captures the ALU result (or LSU data or an immediate) into the destination register. It holds 16 x 8-bit registers: R0-R12 are general purpose, and R13-R15 are read-only thread-context registers. Operand reads are registered, with same-cycle write-to-read bypass, so back-to-back dependent instructions see fresh data.

---
 rtl/thread_registers.sv | 100 ++++++++++
 tb/tb_thread_registers.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/thread_registers.sv
// thread_registers: per-thread 16 x 8-bit register file feeding the ALU.
// R0-R12 general purpose, R13 mirrors block_id, R14 = blockDim, R15 = threadIdx.
// Operands are registered with same-cycle write-to-read bypass.
module thread_registers #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] block_id,
  input  logic       read_en,
  input  logic [3:0] rs_addr,
  input  logic [3:0] rt_addr,
  output logic [7:0] rs,
  output logic [7:0] rt,
  input  logic       wb_en,
  input  logic [3:0] rd_addr,
  input  logic [1:0] reg_input_mux,
  input  logic [7:0] alu_out,
  input  logic [7:0] lsu_out,
  input  logic [7:0] immediate
);

  localparam int         VEC_W    = 8;
  localparam int         NUM_REGS = 16;
  localparam int         NUM_GPR  = 13;
  localparam logic [3:0] LAST_GPR = 4'd12;

  localparam logic [31:0] TPB_W = THREADS_PER_BLOCK;
  localparam logic [31:0] TID_W = THREAD_ID;
  localparam logic [VEC_W-1:0] TPB8 = TPB_W[VEC_W-1:0];
  localparam logic [VEC_W-1:0] TID8 = TID_W[VEC_W-1:0];

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LSU  = 2'b01;
  localparam logic [1:0] SRC_IMM  = 2'b10;
  localparam logic [1:0] SRC_NONE = 2'b11;

  logic [NUM_GPR-1:0][VEC_W-1:0]  gpr;
  logic [VEC_W-1:0]               r13;
  logic [VEC_W-1:0]               wr_data;
  logic                           wr_qual;
  logic [NUM_REGS-1:0][VEC_W-1:0] rf_view;

  // Writeback source select.
  always_comb begin
    wr_data = '0;
    case (reg_input_mux)
      SRC_ALU: wr_data = alu_out;
      SRC_LSU: wr_data = lsu_out;
      SRC_IMM: wr_data = immediate;
      default: wr_data = '0;
    endcase
  end

  // A write lands only on a GPR with a real source; R13-R15 writes are dropped.
  always_comb begin
    wr_qual = enable && wb_en && (rd_addr <= LAST_GPR) && (reg_input_mux != SRC_NONE);
  end

  // Read view of the whole file as seen this cycle, including the in-flight write.
  // R13 reads the live block_id; a frozen lane exposes its held copy instead.
  always_comb begin
    rf_view = '0;
    for (int i = 0; i < NUM_GPR; i++) rf_view[i] = gpr[i];
    rf_view[13] = enable ? block_id : r13;
    rf_view[14] = TPB8;
    rf_view[15] = TID8;
    if (wr_qual) rf_view[rd_addr] = wr_data;
  end

  // One flop bank per general-purpose register.
  for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
    localparam logic [3:0] IDX = 4'(g);
    // Capture writeback data when this register is the qualified destination.
    always_ff @(posedge clk) begin
      if (reset)                          gpr[g] <= '0;
      else if (wr_qual && rd_addr == IDX) gpr[g] <= wr_data;
    end
  end

  // R13 tracks block_id every active cycle.
  always_ff @(posedge clk) begin
    if (reset)       r13 <= '0;
    else if (enable) r13 <= block_id;
  end

  // Registered operands; hold unless the lane is active and a read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs <= '0;
      rt <= '0;
    end else if (enable && read_en) begin
      rs <= rf_view[rs_addr];
      rt <= rf_view[rt_addr];
    end
  end

endmodule

// File: tb/tb_thread_registers.sv
// Scoreboard bench for thread_registers: a reference model pushes the expected
// operands each cycle, and they are popped and compared after the clock edge.
module tb_thread_registers;

  localparam int         TPB     = 4;
  localparam int         TID     = 2;
  localparam logic [7:0] EXP_TPB = 8'd4;
  localparam logic [7:0] EXP_TID = 8'd2;

  logic       clk = 1'b0;
  logic       reset, enable, read_en, wb_en;
  logic [7:0] block_id, alu_out, lsu_out, immediate;
  logic [3:0] rs_addr, rt_addr, rd_addr;
  logic [1:0] reg_input_mux;
  logic [7:0] rs, rt;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [7:0] rs;
    logic [7:0] rt;
  } exp_t;
  exp_t sbq[$];

  // model state
  logic [7:0] m_reg [0:12];
  logic [7:0] m_rs, m_rt;

  thread_registers #(.THREADS_PER_BLOCK(TPB), .THREAD_ID(TID)) dut (
    .clk(clk), .reset(reset), .enable(enable), .block_id(block_id),
    .read_en(read_en), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs(rs), .rt(rt), .wb_en(wb_en), .rd_addr(rd_addr),
    .reg_input_mux(reg_input_mux), .alu_out(alu_out), .lsu_out(lsu_out),
    .immediate(immediate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_wdata();
    case (reg_input_mux)
      2'b00:   return alu_out;
      2'b01:   return lsu_out;
      2'b10:   return immediate;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a, input logic wq, input logic [7:0] wd);
    if (wq && a == rd_addr) return wd;
    case (a)
      4'd13:   return block_id;
      4'd14:   return EXP_TPB;
      4'd15:   return EXP_TID;
      default: return m_reg[a];
    endcase
  endfunction

  // Model one edge from the currently driven inputs, push the expectation,
  // clock the DUT and compare the popped entry.
  task automatic step(input string tag);
    logic       wq;
    logic [7:0] wd;
    exp_t       e;
    if (reset) begin
      for (int i = 0; i < 13; i++) m_reg[i] = 8'h00;
      m_rs = 8'h00;
      m_rt = 8'h00;
    end else if (enable) begin
      wd = m_wdata();
      wq = wb_en && (rd_addr < 4'd13) && (reg_input_mux != 2'b11);
      if (read_en) begin
        m_rs = m_read(rs_addr, wq, wd);
        m_rt = m_read(rt_addr, wq, wd);
      end
      if (wq) m_reg[rd_addr] = wd;
    end
    sbq.push_back('{tag: tag, rs: m_rs, rt: m_rt});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.tag, ".rs"}, {24'h0, rs}, {24'h0, e.rs});
    chk({e.tag, ".rt"}, {24'h0, rt}, {24'h0, e.rt});
  endtask

  task automatic idle();
    wb_en = 1'b0; read_en = 1'b0; reg_input_mux = 2'b11;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b);
    read_en = 1'b1; rs_addr = a; rt_addr = b;
  endtask

  task automatic wr(input logic [3:0] d, input logic [1:0] mux, input logic [7:0] v);
    wb_en = 1'b1; rd_addr = d; reg_input_mux = mux;
    alu_out = v; lsu_out = v; immediate = v;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; block_id = 8'h00;
    rs_addr = '0; rt_addr = '0; rd_addr = '0;
    alu_out = '0; lsu_out = '0; immediate = '0;
    idle();
    #1;
    step("reset0");
    step("reset1");
    chk("reset_rs", {24'h0, rs}, 32'h0);
    chk("reset_rt", {24'h0, rt}, 32'h0);
    reset = 1'b0;

    // thread-context registers
    idle(); rd(4'd14, 4'd15); step("rd_r14_r15");
    chk("r14_lit", {24'h0, rs}, 32'h4);
    chk("r15_lit", {24'h0, rt}, 32'h2);
    idle(); rd(4'd0, 4'd12); step("rd_r0_r12");
    chk("r0_lit", {24'h0, rs}, 32'h0);

    // writeback from each source
    idle(); wr(4'd3, 2'b00, 8'h2A); alu_out = 8'h2A; lsu_out = 8'hEE; immediate = 8'hDD;
    step("wr_alu");
    idle(); rd(4'd3, 4'd0); step("rd_r3");
    chk("r3_alu", {24'h0, rs}, 32'h2A);
    idle(); wr(4'd4, 2'b01, 8'h11); alu_out = 8'hEE; immediate = 8'hDD;
    step("wr_lsu");
    idle(); rd(4'd4, 4'd3); step("rd_r4");
    chk("r4_lsu", {24'h0, rs}, 32'h11);
    idle(); wr(4'd5, 2'b10, 8'h7F); alu_out = 8'hEE; lsu_out = 8'hDD;
    step("wr_imm");
    idle(); rd(4'd5, 4'd4); step("rd_r5");
    chk("r5_imm", {24'h0, rs}, 32'h7F);

    // same-cycle bypass on both ports
    idle(); wr(4'd7, 2'b10, 8'h55); rd(4'd7, 4'd7); step("bypass_r7");
    chk("bypass_rs", {24'h0, rs}, 32'h55);
    chk("bypass_rt", {24'h0, rt}, 32'h55);
    // bypass on rt only, rs reads a different register
    idle(); wr(4'd8, 2'b00, 8'hC3); rd(4'd7, 4'd8); step("bypass_rt_only");
    chk("bypass_rt8", {24'h0, rt}, 32'hC3);

    // protected registers
    idle(); wr(4'd15, 2'b10, 8'hFF); rd(4'd15, 4'd14); step("wr_r15");
    chk("r15_protect", {24'h0, rs}, 32'h2);
    idle(); wr(4'd14, 2'b00, 8'hFF); rd(4'd14, 4'd15); step("wr_r14");
    chk("r14_protect", {24'h0, rs}, 32'h4);
    idle(); block_id = 8'h09; rd(4'd13, 4'd13); step("rd_r13");
    chk("r13_blockid", {24'h0, rs}, 32'h09);
    idle(); wr(4'd13, 2'b10, 8'hAB); rd(4'd13, 4'd0); step("wr_r13");
    chk("r13_protect", {24'h0, rs}, 32'h09);
    idle(); wr(4'd3, 2'b11, 8'h99); rd(4'd3, 4'd3); step("mux_none");
    chk("mux11_bypass", {24'h0, rs}, 32'h2A);
    idle(); rd(4'd3, 4'd3); step("mux_none_after");
    chk("mux11_kept", {24'h0, rs}, 32'h2A);

    // freeze
    idle(); wr(4'd1, 2'b00, 8'h10); step("wr_r1");
    idle(); rd(4'd1, 4'd7); step("rd_r1");
    chk("r1_val", {24'h0, rs}, 32'h10);
    enable = 1'b0; idle(); wr(4'd1, 2'b00, 8'h20); rd(4'd5, 4'd5); block_id = 8'h44;
    step("frozen0");
    step("frozen1");
    chk("freeze_rs", {24'h0, rs}, 32'h10);
    chk("freeze_rt", {24'h0, rt}, 32'h55);
    enable = 1'b1; idle(); block_id = 8'h09; rd(4'd1, 4'd1); step("unfreeze");
    chk("r1_after_freeze", {24'h0, rs}, 32'h10);

    // reset mid-operation
    idle(); reset = 1'b1; wr(4'd2, 2'b00, 8'h33); rd(4'd2, 4'd2); step("reset_midop");
    chk("midop_rs", {24'h0, rs}, 32'h0);
    chk("midop_rt", {24'h0, rt}, 32'h0);
    reset = 1'b0; idle(); rd(4'd2, 4'd1); step("rd_r2_after");
    chk("r2_cleared", {24'h0, rs}, 32'h0);
    chk("r1_cleared", {24'h0, rt}, 32'h0);
    idle(); rd(4'd15, 4'd14); step("ctx_after_reset");
    chk("r15_after_reset", {24'h0, rs}, 32'h2);

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      enable        = ($urandom_range(0, 7) != 0);
      block_id      = 8'($urandom);
      read_en       = 1'($urandom);
      rs_addr       = 4'($urandom);
      rt_addr       = ($urandom_range(0, 3) == 0) ? rd_addr : 4'($urandom);
      wb_en         = 1'($urandom);
      rd_addr       = 4'($urandom);
      reg_input_mux = 2'($urandom);
      alu_out       = 8'($urandom);
      lsu_out       = 8'($urandom);
      immediate     = 8'($urandom);
      step("rand");
    end

    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
